// File: rtl/cuckoo_lookup_if.sv
// Lookup, table-programming and result bundle for the cuckoo exact-match pipe.
// Channel c occupies slice c of every per-channel vector.
interface cuckoo_lookup_if #(
  parameter int NUM_CH    = 2,
  parameter int HASH_W    = 10,
  parameter int PAT_BYTES = 12,
  parameter int WIN_W     = 160,
  parameter int CNT_W     = 16
);
  localparam int PW   = PAT_BYTES * 8;
  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  logic                       enable;
  logic                       in_valid;
  logic [NUM_CH*HASH_W-1:0]   pre_h1;
  logic [NUM_CH*HASH_W-1:0]   pre_h2;
  logic [NUM_CH*WIN_W-1:0]    win;
  logic                       cfg_we;
  logic                       cfg_sel;
  logic [CH_W-1:0]            cfg_ch;
  logic [HASH_W:0]            cfg_addr;
  logic [PW+2:0]              cfg_wdata;
  logic                       cnt_clr;
  logic                       out_valid;
  logic [NUM_CH*2-1:0]        match;
  logic [NUM_CH*2-1:0]        suffix;
  logic                       hit_any;
  logic [NUM_CH*CNT_W-1:0]    hit_cnt;

  modport master (
    output enable, in_valid, pre_h1, pre_h2, win,
    output cfg_we, cfg_sel, cfg_ch, cfg_addr, cfg_wdata, cnt_clr,
    input  out_valid, match, suffix, hit_any, hit_cnt
  );

  modport slave (
    input  enable, in_valid, pre_h1, pre_h2, win,
    input  cfg_we, cfg_sel, cfg_ch, cfg_addr, cfg_wdata, cnt_clr,
    output out_valid, match, suffix, hit_any, hit_cnt
  );
endinterface

// File: rtl/cuckoo_lookup_pipe.sv
// Multi-channel cuckoo-hash exact-match engine: hash, index read,
// pattern read, compare; stallable 4-stage pipe with hit counters.
module cuckoo_lookup_pipe #(
  parameter int NUM_CH    = 2,
  parameter int HASH_W    = 10,
  parameter int IDX_W     = 9,
  parameter int PAT_BYTES = 12,
  parameter int WIN_W     = 160,
  parameter int CNT_W     = 16
) (
  input logic            clk,
  input logic            rst,
  cuckoo_lookup_if.slave bus
);
  localparam int PW   = PAT_BYTES * 8;
  localparam int EW   = PW + 3;
  localparam int AW   = HASH_W + 1;
  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  typedef struct packed {
    logic [HASH_W-1:0] a1;
    logic [HASH_W-1:0] a2;
    logic [PW-1:0]     key;
  } s1_t;

  typedef struct packed {
    logic [IDX_W-1:0] ia;
    logic [IDX_W-1:0] ib;
    logic [PW-1:0]    key;
  } s2_t;

  typedef struct packed {
    logic [EW-1:0] ea;
    logic [EW-1:0] eb;
    logic [PW-1:0] key;
  } s3_t;

  function automatic logic [HASH_W-1:0] hash_f(
    input logic [HASH_W-1:0] p,
    input logic [7:0]        b
  );
    logic [HASH_W-1:0] sum;
    sum = {p[HASH_W-4:0], 3'b000}
        + {3'b000, p[HASH_W-1:3]}
        + HASH_W'(b);
    return sum ^ p;
  endfunction

  logic                v1, v2, v3, ov;
  logic [2*NUM_CH-1:0] match_v;
  logic [2*NUM_CH-1:0] suffix_v;

  always_ff @(posedge clk) begin
    if (rst) begin
      v1 <= 1'b0;
      v2 <= 1'b0;
      v3 <= 1'b0;
      ov <= 1'b0;
    end else if (bus.enable) begin
      v1 <= bus.in_valid;
      v2 <= v1;
      v3 <= v2;
      ov <= v3;
    end
  end

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    logic [IDX_W-1:0] idx_mem [2**AW];
    logic [EW-1:0]    pat_mem [2**IDX_W];
    s1_t              s1;
    s2_t              s2;
    s3_t              s3;
    logic [WIN_W-1:0] w;
    logic             wr;
    logic             hit_a;
    logic             hit_b;
    logic [1:0]       suf_n;
    logic [1:0]       match_q;
    logic [1:0]       suffix_q;
    logic [CNT_W-1:0] cnt;
    logic             unused_win;

    assign w          = bus.win[c*WIN_W +: WIN_W];
    assign unused_win = ^{w[WIN_W-1:PW+32], w[31:8]};
    assign wr         = bus.cfg_we && (bus.cfg_ch == CH_W'(c));

    // Write-after-read in the same edge gives read-first behaviour
    always_ff @(posedge clk) begin
      if (wr && !bus.cfg_sel)
        idx_mem[bus.cfg_addr] <= bus.cfg_wdata[IDX_W-1:0];
      if (wr && bus.cfg_sel)
        pat_mem[bus.cfg_addr[IDX_W-1:0]] <= bus.cfg_wdata;
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        s1 <= '0;
        s2 <= '0;
        s3 <= '0;
      end else if (bus.enable) begin
        s1.a1  <= hash_f(bus.pre_h1[c*HASH_W +: HASH_W], w[7:0]);
        s1.a2  <= hash_f(bus.pre_h2[c*HASH_W +: HASH_W], w[7:0]);
        s1.key <= w[PW+31:32];
        s2.ia  <= idx_mem[{1'b0, s1.a1}];
        s2.ib  <= idx_mem[{1'b1, s1.a2}];
        s2.key <= s1.key;
        s3.ea  <= pat_mem[s2.ia];
        s3.eb  <= pat_mem[s2.ib];
        s3.key <= s2.key;
      end
    end

    assign hit_a = s3.ea[EW-1] && (s3.ea[PW-1:0] == s3.key);
    assign hit_b = s3.eb[EW-1] && (s3.eb[PW-1:0] == s3.key);

    always_comb begin
      suf_n = 2'b00;
      if (hit_a)
        suf_n = s3.ea[PW+1:PW];
      else if (hit_b)
        suf_n = s3.eb[PW+1:PW];
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        match_q  <= 2'b00;
        suffix_q <= 2'b00;
      end else if (bus.enable) begin
        match_q  <= v3 ? {hit_b, hit_a} : 2'b00;
        suffix_q <= v3 ? suf_n : 2'b00;
      end
    end

    // Counts the result as it is registered, so a stall never recounts
    always_ff @(posedge clk) begin
      if (rst)
        cnt <= '0;
      else if (bus.cnt_clr)
        cnt <= '0;
      else if (bus.enable && v3 && (hit_a || hit_b) && (cnt != '1))
        cnt <= cnt + CNT_W'(1);
    end

    assign match_v[2*c +: 2]              = match_q;
    assign suffix_v[2*c +: 2]             = suffix_q;
    assign bus.hit_cnt[c*CNT_W +: CNT_W]  = cnt;
  end

  assign bus.out_valid = ov;
  assign bus.match     = match_v;
  assign bus.suffix    = suffix_v;
  assign bus.hit_any   = ov & (|match_v);
endmodule

// File: tb/tb_cuckoo_lookup_pipe.sv
// Directed bench for cuckoo_lookup_pipe (4-bit counters to reach saturation).
// Channel 1 always looks up all-zero inputs, which resolve to an invalid entry.
module tb_cuckoo_lookup_pipe;
  localparam int CW = 4;

  localparam logic [9:0]  H1   = 10'h005;
  localparam logic [9:0]  H2   = 10'h0F3;
  localparam logic [7:0]  HB   = 8'h3C;
  localparam logic [10:0] A_H1 = 11'h061;
  localparam logic [10:0] A_H2 = 11'h701;
  localparam logic [9:0]  Q1   = 10'h2A1;
  localparam logic [9:0]  Q2   = 10'h155;
  localparam logic [7:0]  QB   = 8'h77;
  localparam logic [10:0] A_Q1 = 11'h372;
  localparam logic [10:0] A_Q2 = 11'h61C;
  localparam logic [95:0] P    = 96'h0123_4567_89AB_CDEF_FEDC_BA98;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  cuckoo_lookup_if #(.CNT_W(CW)) bus ();

  cuckoo_lookup_pipe #(.CNT_W(CW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [127:0] obs,
                     input logic [127:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [9:0] p1,
                       input logic [9:0] p2, input logic [95:0] pat,
                       input logic [7:0] b);
    bus.in_valid = v;
    bus.pre_h1   = {10'h000, p1};
    bus.pre_h2   = {10'h000, p2};
    bus.win      = {160'h0, 32'hDEAD_BEEF, pat, 24'hA5_A5A5, b};
  endtask

  task automatic idle();
    drive(1'b0, 10'h0, 10'h0, 96'h0, 8'h0);
  endtask

  task automatic cfg(input logic sel, input logic ch,
                     input logic [10:0] addr, input logic [98:0] d);
    bus.cfg_we    = 1'b1;
    bus.cfg_sel   = sel;
    bus.cfg_ch    = ch;
    bus.cfg_addr  = addr;
    bus.cfg_wdata = d;
    step();
    bus.cfg_we    = 1'b0;
  endtask

  // Issues one lookup and returns once its result is on the outputs
  task automatic lookup(input logic [9:0] p1, input logic [9:0] p2,
                        input logic [95:0] pat, input logic [7:0] b);
    drive(1'b1, p1, p2, pat, b);
    step();
    idle();
    step();
    step();
    step();
  endtask

  initial begin
    logic [95:0] px;
    logic [1:0]  got[$];
    logic [1:0]  exp_m;
    logic        en;
    logic        prev_ov;
    logic [3:0]  prev_m;
    logic        seen;
    int          k;

    px = P ^ (96'd1 << 40);
    bus.enable    = 1'b0;
    bus.cfg_we    = 1'b0;
    bus.cfg_sel   = 1'b0;
    bus.cfg_ch    = 1'b0;
    bus.cfg_addr  = '0;
    bus.cfg_wdata = '0;
    bus.cnt_clr   = 1'b0;
    idle();

    step();
    step();
    chk("rst_out_valid", bus.out_valid, 1'b0);
    chk("rst_match", bus.match, 4'h0);
    chk("rst_suffix", bus.suffix, 4'h0);
    chk("rst_hit_any", bus.hit_any, 1'b0);
    chk("rst_hit_cnt", bus.hit_cnt, 8'h00);
    rst = 1'b0;

    cfg(1'b0, 1'b0, A_H1, 99'd5);
    cfg(1'b0, 1'b0, A_H2, 99'd0);
    cfg(1'b0, 1'b0, A_Q1, 99'd5);
    cfg(1'b0, 1'b0, A_Q2, 99'd7);
    cfg(1'b0, 1'b1, 11'h000, 99'd0);
    cfg(1'b0, 1'b1, 11'h400, 99'd0);
    cfg(1'b1, 1'b0, 11'd0, 99'd0);
    cfg(1'b1, 1'b1, 11'd0, 99'd0);
    cfg(1'b1, 1'b0, 11'd5, {1'b1, 2'b10, P});
    bus.enable = 1'b1;

    // single-way hit
    drive(1'b1, H1, H2, P, HB);
    step();
    idle();
    step();
    step();
    chk("t1_latency_ov", bus.out_valid, 1'b0);
    step();
    chk("t1_out_valid", bus.out_valid, 1'b1);
    chk("t1_match", bus.match, 4'b0001);
    chk("t1_suffix", bus.suffix, 4'b0010);
    chk("t1_hit_any", bus.hit_any, 1'b1);
    chk("t1_cnt", bus.hit_cnt, {4'd0, 4'd1});
    step();
    chk("t1_bubble_ov", bus.out_valid, 1'b0);
    chk("t1_bubble_match", bus.match, 4'b0000);

    // both ways hit, way A suffix wins
    cfg(1'b1, 1'b0, 11'd5, {1'b1, 2'b01, P});
    cfg(1'b1, 1'b0, 11'd7, {1'b1, 2'b11, P});
    lookup(Q1, Q2, P, QB);
    chk("t2_match", bus.match, 4'b0011);
    chk("t2_suffix", bus.suffix, 4'b0001);
    chk("t2_cnt", bus.hit_cnt[3:0], 4'd2);

    // invalid entry, then one byte off
    cfg(1'b1, 1'b0, 11'd5, {1'b0, 2'b01, P});
    lookup(H1, H2, P, HB);
    chk("t3_inv_ov", bus.out_valid, 1'b1);
    chk("t3_inv_match", bus.match, 4'b0000);
    chk("t3_inv_hit_any", bus.hit_any, 1'b0);
    cfg(1'b1, 1'b0, 11'd5, {1'b1, 2'b01, P});
    lookup(H1, H2, px, HB);
    chk("t3_byte_match", bus.match, 4'b0000);
    chk("t3_byte_suffix", bus.suffix, 4'b0000);
    chk("t3_cnt", bus.hit_cnt[3:0], 4'd2);

    // 8 back-to-back lookups with a 3-cycle stall; in_valid held high
    k = 0;
    for (int cyc = 0; cyc < 20; cyc++) begin
      en = !(cyc >= 4 && cyc < 7);
      bus.enable = en;
      if (k < 8)
        drive(1'b1, H1, H2, (k % 2 == 0) ? P : px, HB);
      else
        idle();
      prev_ov = bus.out_valid;
      prev_m  = bus.match;
      step();
      if (en && k < 8)
        k++;
      if (!en) begin
        chk("t4_hold_ov", bus.out_valid, prev_ov);
        chk("t4_hold_match", bus.match, prev_m);
      end else if (bus.out_valid) begin
        got.push_back(bus.match[1:0]);
      end
    end
    bus.enable = 1'b1;
    chk("t4_count", got.size(), 8);
    for (int i = 0; i < 8; i++) begin
      exp_m = (i % 2 == 0) ? 2'b01 : 2'b00;
      chk($sformatf("t4_res%0d", i),
          (i < got.size()) ? got[i] : 2'bxx, exp_m);
    end
    chk("t4_cnt", bus.hit_cnt[3:0], 4'd6);

    // index rewritten on the edge the first lookup reads it
    cfg(1'b1, 1'b0, 11'd9, {1'b1, 2'b11, P});
    drive(1'b1, H1, H2, P, HB);
    step();
    bus.cfg_we    = 1'b1;
    bus.cfg_sel   = 1'b0;
    bus.cfg_ch    = 1'b0;
    bus.cfg_addr  = A_H1;
    bus.cfg_wdata = 99'd9;
    step();
    bus.cfg_we = 1'b0;
    idle();
    step();
    step();
    chk("t5_old_match", bus.match, 4'b0001);
    chk("t5_old_suffix", bus.suffix, 4'b0001);
    step();
    chk("t5_new_match", bus.match, 4'b0001);
    chk("t5_new_suffix", bus.suffix, 4'b0011);
    chk("t5_cnt", bus.hit_cnt[3:0], 4'd8);

    // saturation, clear-over-increment, reset flush
    bus.cnt_clr = 1'b1;
    step();
    bus.cnt_clr = 1'b0;
    chk("t6_clr", bus.hit_cnt[3:0], 4'd0);
    for (int i = 0; i < 15; i++) begin
      drive(1'b1, H1, H2, P, HB);
      step();
    end
    idle();
    step();
    step();
    step();
    chk("t6_full", bus.hit_cnt[3:0], 4'hF);
    lookup(H1, H2, P, HB);
    chk("t6_sat_match", bus.match, 4'b0001);
    chk("t6_sat", bus.hit_cnt[3:0], 4'hF);
    drive(1'b1, H1, H2, P, HB);
    step();
    idle();
    step();
    step();
    bus.cnt_clr = 1'b1;
    step();
    bus.cnt_clr = 1'b0;
    chk("t6_clrhit_ov", bus.out_valid, 1'b1);
    chk("t6_clrhit_match", bus.match, 4'b0001);
    chk("t6_clrhit_cnt", bus.hit_cnt[3:0], 4'd0);
    drive(1'b1, H1, H2, P, HB);
    step();
    step();
    idle();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("t6_rst_ov", bus.out_valid, 1'b0);
    seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      step();
      seen = seen | bus.out_valid;
    end
    chk("t6_flush", seen, 1'b0);
    chk("t6_rst_cnt", bus.hit_cnt, 8'h00);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
